// File: rtl/sram_sp_req_ctrl.sv
// sram_sp_req_ctrl: requester-side controller for the single-port SRAM wrapper.
// Turns a valid/ready request stream into the wrapper's pins and returns read data in
// request order through a response FIFO. Read issue is gated by a credit count, so the
// FIFO always has room for every read that is in flight.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_valid/req_ready/req_wr/
//   req_addr/req_wdata                 request channel (req_wr=1 write, 0 read)
//   rsp_valid/rsp_ready/rsp_rdata      read response channel, in read order
//   sram_addr/sram_wen/sram_ren/
//   sram_wdata/sram_rdata              wrapper pins
//   busy                               reads outstanding (pipe + FIFO) != 0
module sram_sp_req_ctrl #(
    parameter int unsigned DATA_BIT       = 32,
    parameter int unsigned DEPTH          = 512,
    parameter int unsigned ADDR_BIT       = $clog2(DEPTH),
    parameter int unsigned RD_LAT         = 2,
    parameter int unsigned RSP_FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [ADDR_BIT-1:0] req_addr,
    input  logic [DATA_BIT-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_BIT-1:0] rsp_rdata,
    output logic [ADDR_BIT-1:0] sram_addr,
    output logic                sram_wen,
    output logic                sram_ren,
    output logic [DATA_BIT-1:0] sram_wdata,
    input  logic [DATA_BIT-1:0] sram_rdata,
    output logic                busy
);

    localparam int unsigned OCC_W = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

    logic [OCC_W-1:0]    occ;
    logic [OCC_W-1:0]    count;
    logic [RD_LAT-1:0]   pipe;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [DATA_BIT-1:0] mem [RSP_FIFO_DEPTH];
    logic                fire;
    logic                push;
    logic                pop;

    // Pointer increment that wraps at the FIFO depth (any depth, not just powers of 2).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request acceptance and SRAM pin pass-through.
    always_comb begin
        req_ready  = rst_n && (occ < OCC_W'(RSP_FIFO_DEPTH));
        fire       = req_valid && req_ready;
        sram_wen   = fire && req_wr;
        sram_ren   = fire && !req_wr;
        sram_addr  = req_addr;
        sram_wdata = req_wdata;
    end

    // Response side: FWFT head, forced to zero when empty so nothing stale is visible.
    always_comb begin
        push      = pipe[RD_LAT-1];
        rsp_valid = (count != '0);
        pop       = rsp_valid && rsp_ready;
        rsp_rdata = rsp_valid ? mem[rd_ptr] : '0;
        busy      = (occ != '0);
    end

    // Credit counter: reads accepted and not yet popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({sram_ren, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Read latency pipe; the tail bit marks the cycle sram_rdata is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe <= RD_LAT'({pipe, sram_ren});
        end
    end

    // FIFO control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are unreachable after reset because count is cleared.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sram_rdata;
    end

    // Credit accounting must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == OCC_W'(RSP_FIFO_DEPTH)) && !pop));

endmodule

// File: tb/tb_sram_sp_req_ctrl.sv
// Testbench for sram_sp_req_ctrl: behavioural SRAM model plus a reference memory and a
// response scoreboard queue filled when requests are accepted.
module tb_sram_sp_req_ctrl;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 512;
    localparam int unsigned AW  = 9;
    localparam int unsigned LAT = 2;
    localparam int unsigned FD  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_wen, sram_ren;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [DW-1:0] ref_mem [DEP];
    logic [DW-1:0] exp_q [$];

    // SRAM model: synchronous array, read data valid LAT cycles after ren.
    logic [DW-1:0] sram_mem [DEP];
    logic [DW-1:0] stage [LAT];

    sram_sp_req_ctrl #(
        .DATA_BIT(DW), .DEPTH(DEP), .ADDR_BIT(AW), .RD_LAT(LAT), .RSP_FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_ren(sram_ren),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_wen) sram_mem[sram_addr] <= sram_wdata;
        if (sram_ren) stage[0] <= sram_mem[sram_addr];
        for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
    assign sram_rdata = stage[LAT-1];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop/compare on response handshake, model the request on acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                pops++;
                if (exp_q.size() == 0) check_val("rsp_unexpected", rsp_rdata, 'x);
                else check_val("rsp_data", rsp_rdata, exp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                if (req_wr) ref_mem[req_addr] = req_wdata;
                else exp_q.push_back(ref_mem[req_addr]);
            end
        end
    end

    // Present a request (called at posedge+1); returns just after its accepting edge.
    task automatic issue(input logic wr, input int addr, input logic [DW-1:0] data, output int stalls);
        stalls = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = AW'(addr);
        req_wdata = data;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                return;
            end
            stalls++;
            @(posedge clk); #1;
        end
        check_val("issue_timeout", 1, 0);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_wr    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check_val("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int st, tot, cyc, p0, seen;
        for (int i = 0; i < DEP; i++) begin
            ref_mem[i]  = '0;
            sram_mem[i] = '0;
        end
        rst_n = 1'b0;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with a read presented that must not reach the SRAM.
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_sram_ren", sram_ren, 0);
        check_val("rst_sram_wen", sram_wen, 0);
        check_val("rst_rsp_rdata", rsp_rdata, 0);
        idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: write then read, response valid 3 cycles after the read fire.
        issue(1'b1, 5, 32'hDEADBEEF, st);
        issue(1'b0, 5, '0, st);
        idle();
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) break;
        end
        check_val("t1_latency", cyc, 3);
        check_val("t1_rdata", rsp_rdata, 32'hDEADBEEF);
        drain();

        // 2: preload data=addr, 8 back-to-back reads at full rate.
        for (int a = 0; a < 8; a++) issue(1'b1, a, DW'(a), st);
        tot = 0;
        p0 = pops;
        for (int a = 0; a < 8; a++) begin
            issue(1'b0, a, '0, st);
            tot += st;
        end
        idle();
        check_val("t2_stalls", tot, 0);
        drain();
        check_val("t2_pops", pops - p0, 8);

        // 3: consumer stalled, credits run out after 4 reads; rdata holds.
        rsp_ready = 1'b0;
        for (int a = 2; a < 6; a++) issue(1'b0, a, '0, st);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = AW'(6);
        repeat (4) @(negedge clk);
        check_val("t3_req_ready", req_ready, 0);
        check_val("t3_sram_ren", sram_ren, 0);
        check_val("t3_busy", busy, 1);
        check_val("t3_rsp_valid", rsp_valid, 1);
        check_val("t3_hold_a", rsp_rdata, 2);
        @(negedge clk);
        check_val("t3_hold_b", rsp_rdata, 2);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        issue(1'b0, 6, '0, st);
        issue(1'b0, 7, '0, st);
        idle();
        drain();

        // 4: write-then-read hazard, and a write stalls when credits are exhausted.
        issue(1'b1, 9, 32'h1, st);
        issue(1'b0, 9, '0, st);
        idle();
        drain();
        rsp_ready = 1'b0;
        for (int a = 0; a < 4; a++) issue(1'b0, a, '0, st);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = AW'(20); req_wdata = 32'h55AA;
        @(negedge clk);
        check_val("t4_wr_ready", req_ready, 0);
        check_val("t4_wr_wen", sram_wen, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        issue(1'b1, 20, 32'h55AA, st);
        issue(1'b0, 20, '0, st);
        idle();
        drain();

        // 5: reset with 3 reads in flight discards everything.
        for (int a = 0; a < 3; a++) issue(1'b0, a, '0, st);
        idle();
        rst_n = 1'b0;
        #1;
        check_val("t5_rsp_valid", rsp_valid, 0);
        check_val("t5_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("t5_req_ready", req_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_val("t5_stale", seen, 0);
        @(posedge clk); #1;

        // 6: random reads/writes with random backpressure against the scoreboard.
        for (int c = 0; c < 10000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        idle();
        rsp_ready = 1'b1;
        drain();
        check_val("t6_busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
